kb_scan_decoder: RTL and testbench
==================================

KB_SCAN_DECODER -- requirements
Module: kb_scan_decoder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, giving event FIFO depth (power of two, 2..64).
REQ-002 The block SHALL have parameter EMIT_BREAKS, default 1; when set, break events are enqueued.
REQ-003 The block SHALL have parameter EMIT_MODS, default 0; when set, modifier-key events are enqueued.
REQ-004 The block SHALL have parameter FILTER_REPEAT, default 1; when set, typematic repeats are suppressed.
REQ-005 The block SHALL have port clk, input, 1 bit, the single system clock.
REQ-006 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have port rx_done_tick, input, 1 bit, one-cycle strobe marking a valid scan-code byte.
REQ-008 The block SHALL have port din, input, 8 bits, the scan-code byte qualified by rx_done_tick.
REQ-009 The block SHALL have port rd_en, input, 1 bit, which pops the FIFO head.
REQ-010 The block SHALL have port rd_data, output, 14 bits, the FIFO head as {ext, brk, mods[3:0], code[7:0]}, first-word-fall-through.
REQ-011 The block SHALL have port empty, output, 1 bit, set when the FIFO holds no events.
REQ-012 The block SHALL have port count, output, $clog2(FIFO_DEPTH)+1 bits, the FIFO occupancy.
REQ-013 The block SHALL have port ovf, output, 1 bit, sticky flag set when an event is dropped because the FIFO is full.
REQ-014 The block SHALL have port mods, output, 4 bits, the live modifier state {gui, alt, ctrl, shift}.

Function
REQ-015 The decoder FSM SHALL have states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), and PAUSE (after E1); bytes are consumed only when rx_done_tick=1.
REQ-016 In IDLE: E0->EXT, F0->BRK, E1->PAUSE with skip counter=7; any other byte SHALL complete a make with ext=0 and return to IDLE.
REQ-017 In EXT: F0->EXT_BRK; any other byte SHALL complete a make with ext=1 and return to IDLE.
REQ-018 BRK and EXT_BRK SHALL complete a break with ext=0 or ext=1 respectively on the next byte, then return to IDLE.
REQ-019 PAUSE SHALL discard 7 bytes, then emit a single make event with code=E1, ext=0, and return to IDLE.
REQ-020 The modifier set SHALL be: shift={12,59}, ctrl={14, E0 14}, alt={11, E0 11}, gui={E0 1F, E0 27}; a make sets the bit and a break clears it; left and right keys share one bit.
REQ-021 The fake shifts E0 12 and E0 59 (make or break) SHALL be discarded without any effect.
REQ-022 The mods field of an enqueued event SHALL be the modifier state before that byte is applied.
REQ-023 With FILTER_REPEAT=1, a make identical in {ext, code} to the last unreleased make SHALL be suppressed; a break of that key, or any different make, SHALL re-arm the filter.
REQ-024 An event SHALL be written at edge k+1 when the final byte arrives at edge k; empty SHALL be low after edge k+1, a latency of 2 clocks.
REQ-025 A write to a full FIFO SHALL drop the event and set ovf; when simultaneous with rd_en, it SHALL succeed and ovf SHALL stay clear.
REQ-026 rd_en while empty SHALL be ignored, with count held at 0.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 On rst, the FSM SHALL go to IDLE, mods SHALL be 0, the filter SHALL be cleared, the skip counter SHALL be 0, the FIFO SHALL be emptied, count=0, empty=1, ovf=0, and rd_data=0.
REQ-029 rst asserted mid-sequence (for example after E0 or during PAUSE) SHALL abandon the partial sequence with no event emitted.

Structure
REQ-030 Package kb_pkg SHALL hold the prefix constants E0, E1 and F0, the modifier scan codes, the FSM state enum, and the event-field offsets.
REQ-031 The FIFO SHALL be a sub-module kb_event_fifo, parametrised by width and depth, with the same clk and rst.

Verification
REQ-032 The bench SHALL drive bytes 12, 1C, F0 1C, F0 12 (EMIT_BREAKS=1) and expect events 0_0_0001_1C, then 0_1_0001_1C, with mods=0 at the end.
REQ-033 The bench SHALL drive E0 75, E0 F0 75 and expect events 1_0_0000_75, then 1_1_0000_75.
REQ-034 The bench SHALL drive E1 14 77 E1 F0 14 F0 77 and expect exactly one event, 0_0_0000_E1, with mods unchanged.
REQ-035 The bench SHALL drive 1C three times (FILTER_REPEAT=1), then F0 1C, then 1C, and expect 2 makes and 1 break.
REQ-036 With FIFO_DEPTH=4 and no reads, the bench SHALL drive 5 makes and expect count=4, ovf=1, and the head event equal to the first make; a later rd_en plus write on the same cycle SHALL leave count at 4.
REQ-037 The bench SHALL assert rst after E0 then drive 1C, and expect an event with ext=0 and no residual EXT state.

Source files
------------

// File: rtl/kb_pkg.sv
// Shared constants, types and helpers for the PS/2 set-2 scan-code decoder.
package kb_pkg;

   // Prefix bytes of the set-2 protocol
   localparam logic [7:0] SC_E0 = 8'hE0;
   localparam logic [7:0] SC_E1 = 8'hE1;
   localparam logic [7:0] SC_F0 = 8'hF0;

   // Modifier scan codes (left/right variants map to the same modifier bit)
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_ALT    = 8'h11;
   localparam logic [7:0] SC_LGUI   = 8'h1F;
   localparam logic [7:0] SC_RGUI   = 8'h27;

   // Bit positions inside the 4-bit modifier vector {gui, alt, ctrl, shift}
   localparam int MOD_SHIFT = 0;
   localparam int MOD_CTRL  = 1;
   localparam int MOD_ALT   = 2;
   localparam int MOD_GUI   = 3;

   // Event word layout {ext, brk, mods[3:0], code[7:0]}
   localparam int EV_CODE_LSB = 0;
   localparam int EV_MODS_LSB = 8;
   localparam int EV_BRK_BIT  = 12;
   localparam int EV_EXT_BIT  = 13;
   localparam int EV_W        = 14;

   // Bytes following E1 that belong to the Pause sequence
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_PAUSE
   } dec_state_t;

   // One-hot modifier bit touched by a key, or zero for ordinary keys
   function automatic logic [3:0] mod_mask(input logic ext, input logic [7:0] code);
      logic [3:0] m;
      m = '0;
      if (!ext && (code == SC_LSHIFT || code == SC_RSHIFT)) m[MOD_SHIFT] = 1'b1;
      if (code == SC_CTRL)                                  m[MOD_CTRL]  = 1'b1;
      if (code == SC_ALT)                                   m[MOD_ALT]   = 1'b1;
      if (ext && (code == SC_LGUI || code == SC_RGUI))      m[MOD_GUI]   = 1'b1;
      return m;
   endfunction

   // E0 12 / E0 59 are synthetic shifts the keyboard wraps around some keys
   function automatic logic is_fake_shift(input logic ext, input logic [7:0] code);
      return ext && (code == SC_LSHIFT || code == SC_RSHIFT);
   endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// First-word-fall-through event FIFO with occupancy count and sticky overflow.
module kb_event_fifo #(
   parameter int WIDTH = 14,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             full;
   logic             rd_ok;
   logic             wr_ok;

   assign empty = (cnt == '0);
   assign full  = (cnt == FULL_CNT);
   assign rd_ok = rd_en && !empty;
   // A full FIFO still accepts a write when the head is popped in the same cycle
   assign wr_ok = wr_en && (!full || rd_en);

   assign count   = cnt;
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Pointer, occupancy and overflow bookkeeping; pointers wrap at DEPTH
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         if (wr_en && !wr_ok) ovf <= 1'b1;
      end
   end

   // Storage array write port
   always_ff @(posedge clk) begin
      // NOTE: the array is not reset; empty gates rd_data, so stale contents are never visible.
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/kb_scan_decoder.sv
// PS/2 set-2 scan-code decoder: turns byte streams into make/break events,
// tracks live modifier state, optionally filters typematic repeats, and
// queues events in a FWFT FIFO.
module kb_scan_decoder
   import kb_pkg::*;
#(
   parameter int FIFO_DEPTH    = 8,
   parameter bit EMIT_BREAKS   = 1'b1,
   parameter bit EMIT_MODS     = 1'b0,
   parameter bit FILTER_REPEAT = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx_done_tick,
   input  logic [7:0]                    din,
   input  logic                          rd_en,
   output logic [EV_W-1:0]               rd_data,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          ovf,
   output logic [3:0]                    mods
);

   dec_state_t       state, state_n;
   logic [2:0]       skip, skip_n;
   logic [3:0]       mods_q, mods_n;
   logic             flt_valid, flt_valid_n;
   logic [8:0]       flt_key, flt_key_n;
   logic             ev_valid, ev_valid_n;
   logic [EV_W-1:0]  ev_data, ev_data_n;

   logic             key_done;
   logic             key_ext;
   logic             key_brk;
   logic             pause_done;
   logic [3:0]       key_mask;
   logic             key_held;

   assign mods = mods_q;

   // Decoder state, modifier/filter state and the one-deep event register
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         skip      <= '0;
         mods_q    <= '0;
         flt_valid <= 1'b0;
         flt_key   <= '0;
         ev_valid  <= 1'b0;
         ev_data   <= '0;
      end else begin
         state     <= state_n;
         skip      <= skip_n;
         mods_q    <= mods_n;
         flt_valid <= flt_valid_n;
         flt_key   <= flt_key_n;
         ev_valid  <= ev_valid_n;
         ev_data   <= ev_data_n;
      end
   end

   // Next-state, key completion, modifier update, repeat filter and event build
   always_comb begin
      // NOTE: every signal gets a default up front so no path leaves one unassigned (no latches).
      state_n     = state;
      skip_n      = skip;
      mods_n      = mods_q;
      flt_valid_n = flt_valid;
      flt_key_n   = flt_key;
      ev_valid_n  = 1'b0;
      ev_data_n   = '0;
      key_done    = 1'b0;
      key_ext     = 1'b0;
      key_brk     = 1'b0;
      pause_done  = 1'b0;

      if (rx_done_tick) begin
         case (state)
            ST_IDLE: begin
               if (din == SC_E0) begin
                  state_n = ST_EXT;
               end else if (din == SC_F0) begin
                  state_n = ST_BRK;
               end else if (din == SC_E1) begin
                  state_n = ST_PAUSE;
                  skip_n  = PAUSE_SKIP;
               end else begin
                  key_done = 1'b1;
               end
            end
            ST_EXT: begin
               if (din == SC_F0) begin
                  state_n = ST_EXT_BRK;
               end else begin
                  key_done = 1'b1;
                  key_ext  = 1'b1;
                  state_n  = ST_IDLE;
               end
            end
            ST_BRK: begin
               key_done = 1'b1;
               key_brk  = 1'b1;
               state_n  = ST_IDLE;
            end
            ST_EXT_BRK: begin
               key_done = 1'b1;
               key_ext  = 1'b1;
               key_brk  = 1'b1;
               state_n  = ST_IDLE;
            end
            ST_PAUSE: begin
               // The last of the trailing bytes completes the Pause key
               if (skip <= 3'd1) begin
                  pause_done = 1'b1;
                  skip_n     = '0;
                  state_n    = ST_IDLE;
               end else begin
                  skip_n = skip - 3'd1;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end

      key_mask = mod_mask(key_ext, din);
      key_held = flt_valid && (flt_key == {key_ext, din});

      // Events carry the modifier state as it was before this byte
      ev_data_n[EV_EXT_BIT]          = key_ext;
      ev_data_n[EV_BRK_BIT]          = key_brk;
      ev_data_n[EV_MODS_LSB +: 4]    = mods_q;
      ev_data_n[EV_CODE_LSB +: 8]    = din;

      if (key_done && !is_fake_shift(key_ext, din)) begin
         if (!key_brk) begin
            mods_n = mods_q | key_mask;
            if (!(FILTER_REPEAT && key_held)) begin
               flt_valid_n = 1'b1;
               flt_key_n   = {key_ext, din};
               ev_valid_n  = (key_mask == 4'd0) || EMIT_MODS;
            end
         end else begin
            mods_n = mods_q & ~key_mask;
            if (key_held) flt_valid_n = 1'b0;
            ev_valid_n = EMIT_BREAKS && ((key_mask == 4'd0) || EMIT_MODS);
         end
      end

      // Pause has no break code, so it always emits and re-arms the filter
      if (pause_done) begin
         ev_valid_n                  = 1'b1;
         ev_data_n[EV_EXT_BIT]       = 1'b0;
         ev_data_n[EV_BRK_BIT]       = 1'b0;
         ev_data_n[EV_CODE_LSB +: 8] = SC_E1;
         flt_valid_n                 = 1'b0;
      end
   end

   kb_event_fifo #(
      .WIDTH (EV_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (ev_valid),
      .wr_data (ev_data),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .empty   (empty),
      .count   (count),
      .ovf     (ovf)
   );

endmodule

// File: tb/tb_kb_scan_decoder.sv
// Self-checking bench: scoreboard against a byte-stream reference model on a
// default-parameter instance, plus directed FIFO boundary checks on a depth-4 instance.
module tb_kb_scan_decoder;

   localparam int DEPTH_A = 8;
   localparam int DEPTH_B = 4;
   localparam bit BRK_A   = 1'b1;
   localparam bit MODS_A  = 1'b0;
   localparam bit FILT_A  = 1'b1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: defaults, scoreboard-checked
   logic        rst_a, rx_a, rd_en_a;
   logic [7:0]  din_a;
   logic [13:0] rd_data_a;
   logic        empty_a, ovf_a;
   logic [3:0]  count_a;
   logic [3:0]  mods_a;

   // Instance B: depth 4, directed FIFO boundary checks
   logic        rst_b, rx_b, rd_en_b;
   logic [7:0]  din_b;
   logic [13:0] rd_data_b;
   logic        empty_b, ovf_b;
   logic [2:0]  count_b;
   logic [3:0]  mods_b;

   kb_scan_decoder #(
      .FIFO_DEPTH(DEPTH_A), .EMIT_BREAKS(BRK_A), .EMIT_MODS(MODS_A), .FILTER_REPEAT(FILT_A)
   ) dut_a (
      .clk(clk), .rst(rst_a), .rx_done_tick(rx_a), .din(din_a), .rd_en(rd_en_a),
      .rd_data(rd_data_a), .empty(empty_a), .count(count_a), .ovf(ovf_a), .mods(mods_a)
   );

   kb_scan_decoder #(
      .FIFO_DEPTH(DEPTH_B), .EMIT_BREAKS(1'b1), .EMIT_MODS(1'b0), .FILTER_REPEAT(1'b1)
   ) dut_b (
      .clk(clk), .rst(rst_b), .rx_done_tick(rx_b), .din(din_b), .rd_en(rd_en_b),
      .rd_data(rd_data_b), .empty(empty_b), .count(count_b), .ovf(ovf_b), .mods(mods_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [13:0] exp_q [$];
   bit          directed;

   // Reference model state: raw pending bytes of an unfinished key, live modifiers, held key
   logic [7:0]  pend [$];
   logic [3:0]  m_mods;
   logic        m_armed;
   logic [8:0]  m_last;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [13:0] ev(input logic ext, input logic brk,
                                      input logic [3:0] m, input logic [7:0] code);
      return {ext, brk, m, code};
   endfunction

   function automatic logic [3:0] model_mask(input logic ext, input logic [7:0] code);
      case ({ext, code})
         9'h012, 9'h059: return 4'b0001;
         9'h014, 9'h114: return 4'b0010;
         9'h011, 9'h111: return 4'b0100;
         9'h11F, 9'h127: return 4'b1000;
         default:        return 4'b0000;
      endcase
   endfunction

   task automatic emit(input logic [13:0] e);
      if (!directed) exp_q.push_back(e);
   endtask

   task automatic model_reset();
      pend.delete();
      m_mods  = 4'd0;
      m_armed = 1'b0;
      m_last  = 9'd0;
   endtask

   // Parse the pending byte list as [E0] [F0] code, or E1 plus seven bytes
   task automatic model_byte(input logic [7:0] b);
      int          i;
      logic        ext, brk;
      logic [7:0]  code;
      logic [3:0]  mask, old;
      pend.push_back(b);
      if (pend[0] == 8'hE1) begin
         if (pend.size() == 8) begin
            emit(ev(1'b0, 1'b0, m_mods, 8'hE1));
            m_armed = 1'b0;
            pend.delete();
         end
         return;
      end
      i = 0; ext = 1'b0; brk = 1'b0;
      if (pend[0] == 8'hE0) begin ext = 1'b1; i = 1; end
      if (i < pend.size() && pend[i] == 8'hF0) begin brk = 1'b1; i++; end
      if (i >= pend.size()) return;
      code = pend[i];
      pend.delete();
      if (ext && (code == 8'h12 || code == 8'h59)) return;
      mask = model_mask(ext, code);
      old  = m_mods;
      if (!brk) begin
         m_mods = m_mods | mask;
         if (!(FILT_A && m_armed && m_last == {ext, code})) begin
            m_armed = 1'b1;
            m_last  = {ext, code};
            if (mask == 4'd0 || MODS_A) emit(ev(ext, 1'b0, old, code));
         end
      end else begin
         m_mods = m_mods & ~mask;
         if (m_armed && m_last == {ext, code}) m_armed = 1'b0;
         if (BRK_A && (mask == 4'd0 || MODS_A)) emit(ev(ext, 1'b1, old, code));
      end
   endtask

   task automatic send_a(input logic [7:0] b);
      @(negedge clk);
      rx_a  = 1'b1;
      din_a = b;
      model_byte(b);
      @(negedge clk);
      rx_a  = 1'b0;
      din_a = 8'h00;
      check("mods_live", mods_a, m_mods);
   endtask

   task automatic send_b(input logic [7:0] b);
      @(negedge clk);
      rx_b  = 1'b1;
      din_b = b;
      @(negedge clk);
      rx_b  = 1'b0;
      din_b = 8'h00;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200 && (exp_q.size() != 0 || !empty_a); i++) @(negedge clk);
      check(name, exp_q.size(), 0);
   endtask

   // Monitor: pop and compare every event the DUT presents, reading it out the same cycle
   initial begin
      rd_en_a = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_a || empty_a) begin
            rd_en_a = 1'b0;
         end else begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_event: got 0x%0h, expected none", rd_data_a);
            end else begin
               check("event", rd_data_a, exp_q.pop_front());
            end
            rd_en_a = 1'b1;
         end
      end
   end

   // Watchdog
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
   logic [8:0] keys [11] = '{9'h01C, 9'h012, 9'h059, 9'h014, 9'h114, 9'h011,
                             9'h111, 9'h11F, 9'h127, 9'h175, 9'h01F};
   logic [7:0] drain_codes [4] = '{8'h2A, 8'h1B, 8'h23, 8'h2B};

   initial begin
      logic [8:0] k;
      int         r;
      rst_a = 1'b1; rx_a = 1'b0; din_a = 8'h00;
      rst_b = 1'b1; rx_b = 1'b0; din_b = 8'h00; rd_en_b = 1'b0;
      directed = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;

      check("rst_empty", empty_a, 1);
      check("rst_count", count_a, 0);
      check("rst_ovf", ovf_a, 0);
      check("rst_rd_data", rd_data_a, 0);
      check("rst_mods", mods_a, 0);

      // Shifted make/break of 1C; shift itself produces no events
      exp_q.push_back(ev(1'b0, 1'b0, 4'b0001, 8'h1C));
      exp_q.push_back(ev(1'b0, 1'b1, 4'b0001, 8'h1C));
      send_a(8'h12); send_a(8'h1C); send_a(8'hF0); send_a(8'h1C); send_a(8'hF0); send_a(8'h12);
      drain("drain_shift_key");
      check("mods_after_shift", mods_a, 0);

      // Extended make and break
      exp_q.push_back(ev(1'b1, 1'b0, 4'b0000, 8'h75));
      exp_q.push_back(ev(1'b1, 1'b1, 4'b0000, 8'h75));
      send_a(8'hE0); send_a(8'h75); send_a(8'hE0); send_a(8'hF0); send_a(8'h75);
      drain("drain_ext_key");

      // Pause: one event, embedded 14 must not touch ctrl
      exp_q.push_back(ev(1'b0, 1'b0, 4'b0000, 8'hE1));
      for (int i = 0; i < 8; i++) send_a(pause_seq[i]);
      drain("drain_pause");
      check("mods_after_pause", mods_a, 0);

      // Typematic repeats suppressed until released
      exp_q.push_back(ev(1'b0, 1'b0, 4'b0000, 8'h1C));
      exp_q.push_back(ev(1'b0, 1'b1, 4'b0000, 8'h1C));
      exp_q.push_back(ev(1'b0, 1'b0, 4'b0000, 8'h1C));
      send_a(8'h1C); send_a(8'h1C); send_a(8'h1C); send_a(8'hF0); send_a(8'h1C); send_a(8'h1C);
      drain("drain_repeat");

      // Randomized key traffic against the reference model
      directed = 1'b0;
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 99);
         if (r < 4) begin
            for (int i = 0; i < 8; i++) send_a(pause_seq[i]);
         end else if (r < 10) begin
            send_a(8'hE0);
            if ($urandom_range(0, 1) != 0) send_a(8'hF0);
            send_a(($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59);
         end else if (r < 16) begin
            send_a(8'($urandom_range(0, 255)));
         end else begin
            k = keys[$urandom_range(0, 10)];
            if (k[8]) send_a(8'hE0);
            if ($urandom_range(0, 2) == 0) send_a(8'hF0);
            send_a(k[7:0]);
         end
      end
      while (pend.size() != 0) send_a(8'h1C);
      drain("drain_random");
      check("ovf_random", ovf_a, 0);

      // Reset in the middle of an E0 prefix abandons it
      directed = 1'b1;
      send_a(8'hE0);
      @(negedge clk);
      rst_a = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
      check("rst2_empty", empty_a, 1);
      check("rst2_mods", mods_a, 0);
      exp_q.push_back(ev(1'b0, 1'b0, 4'b0000, 8'h1C));
      send_a(8'h1C);
      drain("drain_after_rst");
      repeat (4) @(negedge clk);

      // Instance B: read while empty, write latency, overflow
      rst_b = 1'b1;
      repeat (2) @(negedge clk);
      rst_b = 1'b0;
      check("b_rst_empty", empty_b, 1);
      check("b_rst_count", count_b, 0);
      rd_en_b = 1'b1;
      @(negedge clk);
      rd_en_b = 1'b0;
      check("b_rd_empty_count", count_b, 0);
      check("b_rd_empty_flag", empty_b, 1);

      send_b(8'h1C);
      check("latency_edge_k", empty_b, 1);
      @(negedge clk);
      check("latency_edge_k1", empty_b, 0);
      check("latency_head", rd_data_b, ev(1'b0, 1'b0, 4'b0000, 8'h1C));
      for (int i = 0; i < 4; i++) send_b(drain_codes[i]);
      @(negedge clk);
      check("full_count", count_b, 4);
      check("full_ovf", ovf_b, 1);
      check("full_head", rd_data_b, ev(1'b0, 1'b0, 4'b0000, 8'h1C));
      send_b(8'h3B);
      rd_en_b = 1'b1;
      @(negedge clk);
      rd_en_b = 1'b0;
      check("full_rw_count", count_b, 4);
      check("full_rw_head", rd_data_b, ev(1'b0, 1'b0, 4'b0000, 8'h2A));

      // Instance B again: simultaneous read+write at full keeps ovf clear, pointers wrap
      rst_b = 1'b1;
      repeat (2) @(negedge clk);
      rst_b = 1'b0;
      check("b_rst2_ovf", ovf_b, 0);
      check("b_rst2_rd_data", rd_data_b, 0);
      send_b(8'h1C);
      for (int i = 0; i < 3; i++) send_b(drain_codes[i]);
      @(negedge clk);
      check("fill4_count", count_b, 4);
      check("fill4_ovf", ovf_b, 0);
      send_b(drain_codes[3]);
      rd_en_b = 1'b1;
      @(negedge clk);
      rd_en_b = 1'b0;
      check("rw_count", count_b, 4);
      check("rw_ovf", ovf_b, 0);
      for (int i = 0; i < 4; i++) begin
         check("wrap_order", rd_data_b, ev(1'b0, 1'b0, 4'b0000, drain_codes[i]));
         rd_en_b = 1'b1;
         @(negedge clk);
      end
      rd_en_b = 1'b0;
      check("wrap_empty", empty_b, 1);
      check("wrap_count", count_b, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
